// File: rtl/parity_pkg.sv
// parity_pkg: shared frame-state encoding and default payload width for the parity blocks.
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} parity_state_e;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/parity_check_rx.sv
// parity_check_rx: deserialises an LSB-first payload plus trailing parity bit,
// accumulating parity serially and counting parity errors with saturation.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PARITY_ODD = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 rx_bit,
  input  logic                 sof,
  output logic [DATA_W-1:0]    data_out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic ODD = (PARITY_ODD != 0);

  parity_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic [DATA_W-1:0]     sh_q, sh_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    sh_d         = sh_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    err_count_d  = err_count_q;
    // sof always wins, even mid-frame or on the parity slot: restart with this bit as bit 0
    if (bit_valid && sof) begin
      sh_d    = DATA_W'(rx_bit);
      par_d   = rx_bit;
      cnt_d   = CW'(1);
      state_d = (DATA_W == 1) ? PARITY : DATA;
    end else if (bit_valid && state_q == DATA) begin
      sh_d    = sh_q | (DATA_W'(rx_bit) << cnt_q);
      par_d   = par_q ^ rx_bit;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_d == CW'(DATA_W)) ? PARITY : DATA;
    end else if (bit_valid && state_q == PARITY) begin
      out_valid_d  = 1'b1;
      data_out_d   = sh_q;
      parity_err_d = par_q ^ rx_bit ^ ODD;
      err_count_d  = (parity_err_d && err_count_q != '1) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
      cnt_d        = '0;
      par_d        = 1'b0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      sh_q         <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      sh_q         <= sh_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != IDLE);
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: directed and randomized frames against a frame-level parity model,
// driving one default instance and one with a 2-bit error counter in lockstep.
module tb_parity_check_rx;
  logic clk = 1'b0;
  logic rst_n, bit_valid, rx_bit, sof;
  logic [31:0] d0, d1;
  logic v0, v1, pe0, pe1, b0, b1;
  logic [7:0] e0;
  logic [1:0] e1;

  always #5 clk = ~clk;

  parity_check_rx u0 (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit), .sof(sof),
    .data_out(d0), .out_valid(v0), .parity_err(pe0), .busy(b0), .err_count(e0)
  );

  parity_check_rx #(.ERR_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit), .sof(sof),
    .data_out(d1), .out_valid(v1), .parity_err(pe1), .busy(b1), .err_count(e1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ov0 = 0;
  int ov1 = 0;
  logic [31:0] m_data = '0;
  logic        m_perr = 1'b0;
  int          m_e0 = 0;
  int          m_e1 = 0;

  always @(posedge clk) begin
    #1;
    if (v0) ov0++;
    if (v1) ov1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic b);
    @(negedge clk);
    bit_valid = v;
    sof       = s;
    rx_bit    = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_outputs(input string tag, input logic ov);
    chk({tag, ".ov0"}, 64'(v0), 64'(ov));
    chk({tag, ".ov1"}, 64'(v1), 64'(ov));
    chk({tag, ".data0"}, 64'(d0), 64'(m_data));
    chk({tag, ".data1"}, 64'(d1), 64'(m_data));
    chk({tag, ".perr0"}, 64'(pe0), 64'(m_perr));
    chk({tag, ".perr1"}, 64'(pe1), 64'(m_perr));
    chk({tag, ".errc0"}, 64'(e0), 64'(m_e0));
    chk({tag, ".errc1"}, 64'(e1), 64'(m_e1));
    chk({tag, ".busy0"}, 64'(b0), 64'(0));
    chk({tag, ".busy1"}, 64'(b1), 64'(0));
  endtask

  task automatic model_reset();
    m_data = '0;
    m_perr = 1'b0;
    m_e0   = 0;
    m_e1   = 0;
  endtask

  task automatic send_frame(input logic [31:0] p, input logic pb, input int maxgap, input string tag);
    int before0, before1;
    before0 = ov0;
    before1 = ov1;
    for (int i = 0; i < 32; i++) begin
      idle($urandom_range(maxgap, 0));
      drive(1'b1, i == 0, p[i]);
    end
    idle($urandom_range(maxgap, 0));
    drive(1'b1, 1'b0, pb);
    m_data = p;
    m_perr = 1'(($countones(p) + int'(pb)) % 2);
    if (m_perr) begin
      m_e0 = (m_e0 < 255) ? m_e0 + 1 : 255;
      m_e1 = (m_e1 < 3) ? m_e1 + 1 : 3;
    end
    drive(1'b0, 1'b0, 1'b0);
    check_outputs({tag, ".done"}, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check_outputs({tag, ".hold"}, 1'b0);
    chk({tag, ".pulses0"}, 64'(ov0 - before0), 64'(1));
    chk({tag, ".pulses1"}, 64'(ov1 - before1), 64'(1));
  endtask

  initial begin
    logic [31:0] p;
    int before0;
    rst_n = 1'b0;
    bit_valid = 1'b0;
    rx_bit = 1'b0;
    sof = 1'b0;
    idle(2);
    check_outputs("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    before0 = ov0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    idle(2);
    chk("idle_no_sof.pulses", 64'(ov0 - before0), 64'(0));
    check_outputs("idle_no_sof", 1'b0);

    send_frame(32'h0000_05D6, 1'b1, 0, "f05d6");
    send_frame(32'h0000_0000, 1'b0, 0, "zero_good");
    send_frame(32'h0000_0000, 1'b1, 0, "zero_bad");
    send_frame(32'h0000_000C, 1'b0, 5, "gaps_000c");

    p = $urandom;
    for (int i = 0; i < 17; i++) drive(1'b1, i == 0, p[i]);
    send_frame(32'hFFFF_FFFF, 1'b0, 0, "restart17");

    p = $urandom;
    for (int i = 0; i < 32; i++) drive(1'b1, i == 0, p[i]);
    send_frame(32'h1234_5678, 1'b1, 1, "restart_on_parity");

    p = $urandom;
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, p[i]);
    drive(1'b0, 1'b0, 1'b0);
    chk("midframe.busy0", 64'(b0), 64'(1));
    chk("midframe.busy1", 64'(b1), 64'(1));
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("async_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    before0 = ov0;
    for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, 1'($urandom));
    idle(2);
    chk("after_reset.pulses", 64'(ov0 - before0), 64'(0));
    check_outputs("after_reset", 1'b0);

    for (int k = 0; k < 8; k++) begin
      send_frame($urandom, 1'($urandom), 3, $sformatf("rand%0d", k));
    end

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    idle(1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      p = $urandom;
      send_frame(p, ~(^p), 2, $sformatf("bad%0d", k));
    end
    chk("sat.errc1", 64'(e1), 64'(3));
    chk("sat.errc0", 64'(e0), 64'(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_check_rx.md
PARITY_CHECK_RX -- requirements
Module: parity_check_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0; 0 selects even parity (parity bit = XOR of data bits), 1 selects odd parity.
REQ-003 The block SHALL have parameter ERR_CNT_W, default 8, giving the width of the error counter.
REQ-004 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port bit_valid, input, 1 bit: rx_bit is sampled on any rising clk edge where bit_valid=1.
REQ-007 Port rx_bit, input, 1 bit: serial line data, LSB of the payload first, then the parity bit.
REQ-008 Port sof, input, 1 bit: start of frame, qualified by bit_valid and marking the first data bit.
REQ-009 Port data_out, output, DATA_W bits: the assembled payload.
REQ-010 Port out_valid, output, 1 bit: one-cycle pulse indicating that data_out and parity_err are valid.
REQ-011 Port parity_err, output, 1 bit: set when the received parity bit mismatches the computed parity.
REQ-012 Port busy, output, 1 bit: high while a frame is in progress (state DATA or PARITY).
REQ-013 Port err_count, output, ERR_CNT_W bits: saturating count of parity errors since reset.

Function
REQ-014 The FSM SHALL have the states IDLE, DATA and PARITY.
REQ-015 In IDLE, bit_valid&sof SHALL load bit 0 of the shift register, initialise the running parity to rx_bit, set the bit counter to 1, and enter DATA.
REQ-016 In IDLE, bit_valid without sof SHALL be ignored.
REQ-017 In DATA, each bit_valid SHALL store rx_bit at the position given by the bit counter, XOR it into the running parity, and increment the counter.
REQ-018 The FSM SHALL move DATA -> PARITY on the cycle the DATA_W-th bit is accepted.
REQ-019 Cycles with bit_valid=0 SHALL hold all state, so gaps of any length are legal.
REQ-020 In PARITY, a bit_valid SHALL be the parity bit; the block SHALL return to IDLE.
REQ-021 On the clock edge that samples the parity bit, the block SHALL register out_valid=1, data_out=payload, and parity_err=(running_parity ^ rx_bit ^ PARITY_ODD).
REQ-022 Latency SHALL be: out_valid high in the cycle immediately after the parity-bit edge, for exactly one cycle.
REQ-023 data_out and parity_err SHALL hold their values until the next out_valid.
REQ-024 err_count SHALL increment in the same edge as an out_valid with parity_err=1, and SHALL saturate at all-ones without wrapping.
REQ-025 When sof is seen with bit_valid in DATA or PARITY, the partial frame SHALL be discarded with no out_valid and no err_count change, and a new frame SHALL start with that bit as bit 0 (same action as REQ-015).
REQ-026 A parity bit arriving with sof=1 SHALL be treated per REQ-025, not as parity.
REQ-027 A frame completing in the same cycle as a new sof cannot occur, because the parity bit is a single sampled bit; no special case is required.
REQ-028 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never exceed DATA_W.

Reset
REQ-029 While rst_n=0, regardless of clk: state=IDLE, counter=0, running parity=0, shift register=0, data_out=0, out_valid=0, parity_err=0, busy=0, err_count=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; the first frame after release SHALL require sof.

Structure
REQ-031 The FSM state encoding (IDLE, DATA, PARITY) and the default DATA_W SHALL live in shared package parity_pkg, which the existing parity generator also uses.
REQ-032 The block SHALL be a single module; the combinational parity function SHALL NOT be instantiated, because parity is accumulated serially.
REQ-033 The implementation SHALL be flat RTL, 120-400 lines.

Verification
REQ-034 Scenario: payload 32'h0000_05D6 (7 ones) with parity bit 1, even mode -> one out_valid, data_out=32'h0000_05D6, parity_err=0, err_count=0.
REQ-035 Scenario: payload 32'h0000_0000 with parity bit 0 -> parity_err=0; the same frame with parity bit 1 -> parity_err=1, err_count=1.
REQ-036 Scenario: payload 32'h0000_000C with parity 0 and random bit_valid gaps of 0-5 cycles -> data_out=32'h0000_000C, parity_err=0, out_valid exactly one cycle after the parity edge.
REQ-037 Scenario: sof re-asserted at bit 17, followed by a full 32'hFFFF_FFFF frame with parity 0 -> a single out_valid, data_out=32'hFFFF_FFFF, parity_err=0.
REQ-038 Scenario: rst_n pulsed low mid-frame at bit 10 -> all outputs 0 asynchronously, no out_valid; bits sent without sof after release are ignored.
REQ-039 Scenario: with ERR_CNT_W=2, 5 bad-parity frames -> err_count sequence 1, 2, 3, 3, 3.
